reg_file: RTL and testbench
===========================

// Module: reg_file
//
// PURPOSE
//   Architectural integer register file for the single-cycle RV32I core.
//   Sits directly downstream of the control unit:
//     - consumes the decoded rs1/rs2/rd fields and reg_write;
//     - supplies both ALU operands and the store-data source;
//     - captures the write-back result.
//   Register x10 (a0) is exposed as a debug/observation port for lab benches.
//
// PARAMETERS
//   DATA_WIDTH   32   width of each register and of all data ports
//   ADDR_WIDTH   5    register index width; depth = 2**ADDR_WIDTH
//   BYPASS       1    1: same-cycle write-to-read forwarding; 0: no forwarding
//   A0_IDX       10   index of the register mirrored on the a0 port
//
// PORTS
//   clk      in   1            rising-edge clock
//   rst_n    in   1            asynchronous active-low reset
//   ad1      in   ADDR_WIDTH   read port 1 index (rs1)
//   ad2      in   ADDR_WIDTH   read port 2 index (rs2)
//   ad3      in   ADDR_WIDTH   write index (rd)
//   we3      in   1            write enable (reg_write from control)
//   wd3      in   DATA_WIDTH   write data (ALU result or memory read data)
//   rd1      out  DATA_WIDTH   read data 1
//   rd2      out  DATA_WIDTH   read data 2
//   a0       out  DATA_WIDTH   registered copy of reg[A0_IDX]
//
// BEHAVIOUR
//   Storage and reset
//   - 2**ADDR_WIDTH registers of DATA_WIDTH bits.
//   - rst_n low asynchronously clears every register and a0 to 0; rd1/rd2 then read 0.
//   - While rst_n is low, writes are ignored. The first write can occur on the
//     first rising edge after rst_n deasserts.
//   Write
//   - On posedge clk with we3=1 and ad3!=0: reg[ad3] <= wd3.
//   - A write to x0 is discarded. reg[0] never leaves 0 (no flop required).
//   Read (combinational, zero latency)
//   - rdN = 0 if adN==0.
//   - Else, if BYPASS=1 and we3=1 and ad3==adN: rdN = wd3 (forward the pending write).
//   - Else rdN = reg[adN].
//   - Both ports are independent. ad1==ad2 is legal and both ports return the same value.
//   a0 port
//   - Updated each posedge to the post-write value of reg[A0_IDX].
//   - A write to A0_IDX is therefore visible on a0 one cycle after the write edge.
//   Boundary conditions
//   - ad3 == max index (31) is written normally; there is no wrap or aliasing.
//   - Simultaneous read and write to the same index:
//       BYPASS=1 -> new data; BYPASS=0 -> old data.
//       The stored value is wd3 after the edge in either case.
//   - Reset asserted mid-cycle with we3=1: the write is lost, all registers read 0.
//   - X/Z on ad3 with we3=0 must not corrupt state. Assert we3 is known out of reset.
//
// TESTING
//   1. Reset hold, then release; read all 32 indices on ad1/ad2
//      -> every value is 0, and a0 = 0.
//   2. we3=1, ad3=5, wd3=32'hDEAD_BEEF, one edge; then ad1=5
//      -> rd1 = 32'hDEAD_BEEF. Other registers are unchanged.
//   3. we3=1, ad3=0, wd3=32'hFFFF_FFFF, one edge; then ad1=ad2=0
//      -> rd1 = rd2 = 0.
//   4. BYPASS=1: with reg[7]=1, drive ad1=7, ad3=7, we3=1, wd3=2 before the edge
//      -> rd1 = 2 pre-edge, and reg[7]=2 post-edge.
//      Repeat with BYPASS=0 -> rd1 = 1 pre-edge.
//   5. Write 32'h0000_002A to x10
//      -> a0 = 0 in the write cycle, a0 = 32'h2A the cycle after.
//      Write x31 = 32'h8000_0000 -> readback is correct.
//   6. Fill x1..x31 with their index; pulse rst_n low asynchronously between edges
//      -> all reads return 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/reg_file.sv
// RV32I architectural register file: two combinational read ports and one write port.
// Optional same-cycle write forwarding; registered observation copy of one register on a0.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          BYPASS     = 1'b1,
  parameter int unsigned A0_IDX     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ad1,
  input  logic [ADDR_WIDTH-1:0] ad2,
  input  logic [ADDR_WIDTH-1:0] ad3,
  input  logic                  we3,
  input  logic [DATA_WIDTH-1:0] wd3,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int unsigned           DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR = ADDR_WIDTH'(A0_IDX);

  // x0 has no storage; mem_view presents it as constant zero.
  logic [DATA_WIDTH-1:0] regs     [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] mem_view [DEPTH];
  logic                  wr_en;

  // Gating with rst_n keeps a write pending during reset from being forwarded.
  assign wr_en = we3 && (ad3 != '0) && rst_n;

  always_comb begin
    mem_view[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      mem_view[i] = regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (ad3 == ADDR_WIDTH'(i)) begin
          regs[i] <= wd3;
        end
      end
    end
  end

  // a0 tracks the post-write value, so a write shows up one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0 <= '0;
    end else if (wr_en && (ad3 == A0_ADDR)) begin
      a0 <= wd3;
    end else begin
      a0 <= mem_view[A0_ADDR];
    end
  end

  assign rd1 = (ad1 == '0)                      ? '0  :
               (BYPASS && wr_en && (ad3 == ad1)) ? wd3 : mem_view[ad1];
  assign rd2 = (ad2 == '0)                      ? '0  :
               (BYPASS && wr_en && (ad3 == ad2)) ? wd3 : mem_view[ad2];

  we3_known_a : assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(we3));

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: forwarding and non-forwarding instances driven in parallel.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ad1, ad2, ad3;
  logic        we3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, a0;
  logic [31:0] nb_rd1, nb_rd2, nb_a0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  ad3;
    logic [31:0] wd;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] ea0;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] ea0;
  } exp_t;

  vec_t tbl [13];
  exp_t sb  [$];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1), .A0_IDX(10)) dut (
    .clk(clk), .rst_n(rst_n), .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .a0(a0)
  );

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0), .A0_IDX(10)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3), .wd3(wd3),
    .rd1(nb_rd1), .rd2(nb_rd2), .a0(nb_a0)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Walks every index on both ports within one half-period, no clock edge involved.
  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      ad1 = 5'(i);
      ad2 = 5'(31 - i);
      #1;
      check($sformatf("%s_rd1[%0d]", tag, i), rd1, mdl[i]);
      check($sformatf("%s_rd2[%0d]", tag, 31 - i), rd2, mdl[31 - i]);
      check($sformatf("%s_nb_rd1[%0d]", tag, i), nb_rd1, mdl[i]);
    end
  endtask

  initial begin
    exp_t e;

    tbl[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd6,  32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd4,  32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd5,  32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0};
    tbl[4]  = '{1'b1, 5'd7,  32'h1,         5'd1,  5'd2,  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{1'b1, 5'd7,  32'h2,         5'd7,  5'd7,  32'h2, 32'h2, 32'h1, 32'h1, 32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd5,  32'h2, 32'hDEAD_BEEF, 32'h2, 32'hDEAD_BEEF, 32'h0};
    tbl[7]  = '{1'b1, 5'd10, 32'h2A,        5'd10, 5'd9,  32'h2A, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,         5'd10, 5'd10, 32'h2A, 32'h2A, 32'h2A, 32'h2A, 32'h2A};
    tbl[9]  = '{1'b1, 5'd31, 32'h8000_0000, 5'd31, 5'd30, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h2A};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd7,  32'h8000_0000, 32'h2, 32'h8000_0000, 32'h2, 32'h2A};
    tbl[11] = '{1'b1, 5'd10, 32'h55,        5'd10, 5'd31, 32'h55, 32'h8000_0000, 32'h2A, 32'h8000_0000, 32'h2A};
    tbl[12] = '{1'b0, 5'd0,  32'h0,         5'd10, 5'd0,  32'h55, 32'h0, 32'h55, 32'h0, 32'h55};

    for (int i = 0; i < 32; i++) mdl[i] = '0;

    // Reset held across edges with a write attempt that must be ignored.
    rst_n = 1'b0; we3 = 1'b1; ad3 = 5'd4; wd3 = 32'hFFFF_FFFF; ad1 = '0; ad2 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; we3 = 1'b0;
    sweep("reset");
    check("reset_a0", a0, 32'h0);

    // Table vectors: expectations queued at drive time, compared pre-edge.
    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      we3 = tbl[k].we; ad3 = tbl[k].ad3; wd3 = tbl[k].wd; ad1 = tbl[k].ad1; ad2 = tbl[k].ad2;
      sb.push_back('{tbl[k].e1, tbl[k].e2, tbl[k].n1, tbl[k].n2, tbl[k].ea0});
      if (tbl[k].we && tbl[k].ad3 != 5'd0) mdl[tbl[k].ad3] = tbl[k].wd;
      @(negedge clk);
      if (sb.size() == 0) begin
        check($sformatf("sb_empty[%0d]", k), 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check($sformatf("vec%0d_rd1", k), rd1, e.e1);
        check($sformatf("vec%0d_rd2", k), rd2, e.e2);
        check($sformatf("vec%0d_nb_rd1", k), nb_rd1, e.n1);
        check($sformatf("vec%0d_nb_rd2", k), nb_rd2, e.n2);
        check($sformatf("vec%0d_a0", k), a0, e.ea0);
        check($sformatf("vec%0d_nb_a0", k), nb_a0, e.ea0);
      end
    end

    // Unknown write index with we3 low must leave all state intact.
    @(posedge clk);
    #1;
    we3 = 1'b0; ad3 = 'x; wd3 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    ad3 = '0;
    sweep("post");
    check("post_a0", a0, 32'h55);

    // Fill x1..x31 with their own index.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk);
      #1;
      we3 = 1'b1; ad3 = 5'(i); wd3 = 32'(i);
    end
    @(posedge clk);
    #1;
    we3 = 1'b0; ad1 = 5'd31; ad2 = 5'd10;
    #1;
    check("fill_rd1_x31", rd1, 32'd31);
    check("fill_rd2_x10", rd2, 32'd10);
    check("fill_a0", a0, 32'd10);

    // Asynchronous reset between edges, with a write pending.
    #20;
    we3 = 1'b1; ad3 = 5'd3; wd3 = 32'h777;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    sweep("async");
    check("async_a0", a0, 32'h0);
    check("async_nb_a0", nb_a0, 32'h0);

    @(posedge clk);
    #1;
    rst_n = 1'b1; we3 = 1'b0; ad1 = 5'd3; ad2 = 5'd10;
    #1;
    check("lost_write_rd1", rd1, 32'h0);
    check("lost_write_nb_rd1", nb_rd1, 32'h0);
    check("lost_write_rd2", rd2, 32'h0);
    we3 = 1'b1; ad3 = 5'd3; wd3 = 32'h33;
    @(posedge clk);
    #1;
    we3 = 1'b0;
    #1;
    check("first_write_rd1", rd1, 32'h33);
    check("first_write_nb_rd1", nb_rd1, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
